// File: rtl/ov7670_config_sequencer.sv
// rtl/ov7670_config_sequencer.sv - walks the OV7670 init ROM and issues SCCB writes
// Optional feature macro: CFG_POST_RESET_DELAY_EN (timed wait after a COM7 soft-reset write)
module ov7670_config_sequencer #(
  parameter int DELAY_CYCLES = 250000,
  parameter int ROM_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        sccb_ready,
  output logic        sccb_start,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  output logic        busy,
  output logic        done,
  output logic [7:0]  write_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT_LO, S_WAIT_HI, S_DELAY, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_rom_addr, w_rom_addr_nxt;
  logic [7:0]  r_sccb_reg, w_sccb_reg_nxt;
  logic [7:0]  r_sccb_val, w_sccb_val_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic [7:0]  r_write_count, w_write_count_nxt;
  logic [7:0]  r_fetch_cnt, w_fetch_cnt_nxt;
  logic [31:0] r_delay_cnt, w_delay_cnt_nxt;
  logic        w_sccb_start;
  logic        w_advance;
  logic        w_soft_reset;

`ifdef CFG_POST_RESET_DELAY_EN
  // COM7 with bit7 set resets the sensor; it needs settling time before further writes
  assign w_soft_reset = (r_sccb_reg == 8'h12) && r_sccb_val[7];
`else
  assign w_soft_reset = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rom_addr    <= 8'd0;
      r_sccb_reg    <= 8'd0;
      r_sccb_val    <= 8'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_write_count <= 8'd0;
      r_fetch_cnt   <= 8'd0;
      r_delay_cnt   <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_rom_addr    <= w_rom_addr_nxt;
      r_sccb_reg    <= w_sccb_reg_nxt;
      r_sccb_val    <= w_sccb_val_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_write_count <= w_write_count_nxt;
      r_fetch_cnt   <= w_fetch_cnt_nxt;
      r_delay_cnt   <= w_delay_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rom_addr_nxt    = r_rom_addr;
    w_sccb_reg_nxt    = r_sccb_reg;
    w_sccb_val_nxt    = r_sccb_val;
    w_busy_nxt        = r_busy;
    w_done_nxt        = r_done;
    w_write_count_nxt = r_write_count;
    w_fetch_cnt_nxt   = r_fetch_cnt;
    w_delay_cnt_nxt   = r_delay_cnt;
    w_sccb_start      = 1'b0;
    w_advance         = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_rom_addr_nxt    = 8'd0;
          w_write_count_nxt = 8'd0;
          w_done_nxt        = 1'b0;
          w_busy_nxt        = 1'b1;
          w_fetch_cnt_nxt   = 8'd0;
          w_state_nxt       = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_fetch_cnt == 8'(ROM_LATENCY)) begin
          w_state_nxt = S_DECODE;
        end else begin
          w_fetch_cnt_nxt = r_fetch_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (rom_data == 16'hFFF0) begin
          w_delay_cnt_nxt = 32'(DELAY_CYCLES - 1);
          w_state_nxt     = S_DELAY;
        end else begin
          w_sccb_reg_nxt = rom_data[15:8];
          w_sccb_val_nxt = rom_data[7:0];
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (sccb_ready) begin
          w_sccb_start = 1'b1;
          w_state_nxt  = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!sccb_ready) w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (sccb_ready) begin
          if (r_write_count != 8'hFF) w_write_count_nxt = r_write_count + 8'd1;
          if (w_soft_reset) begin
            w_delay_cnt_nxt = 32'(DELAY_CYCLES - 1);
            w_state_nxt     = S_DELAY;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (r_delay_cnt == 32'd0) w_advance = 1'b1;
        else                      w_delay_cnt_nxt = r_delay_cnt - 32'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // No wrap past the last ROM address: a full table still terminates
    if (w_advance) begin
      if (r_rom_addr == 8'hFF) begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end else begin
        w_rom_addr_nxt  = r_rom_addr + 8'd1;
        w_fetch_cnt_nxt = 8'd0;
        w_state_nxt     = S_FETCH;
      end
    end
  end

  assign rom_addr    = r_rom_addr;
  assign sccb_start  = w_sccb_start;
  assign sccb_reg    = r_sccb_reg;
  assign sccb_val    = r_sccb_val;
  assign busy        = r_busy;
  assign done        = r_done;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb/tb_ov7670_config_sequencer.sv - directed and randomized bench for ov7670_config_sequencer
// Honours CFG_POST_RESET_DELAY_EN when the build defines it.
module tb_ov7670_config_sequencer;
  localparam int DLY = 16;
`ifdef CFG_POST_RESET_DELAY_EN
  localparam int POST_GAP = DLY;
`else
  localparam int POST_GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        sccb_ready = 1'b1;
  logic        sccb_start;
  logic [7:0]  sccb_reg, sccb_val;
  logic        busy, done;
  logic [7:0]  write_count;

  logic [15:0] rom [256];
  logic [15:0] got_q [$];
  int          pulse_q [$];
  logic [15:0] exp_q [$];
  int          exp_wc, exp_addr;
  int          cyc = 0;
  int          m_lat = 1;
  int          m_cnt = 0;
  bit          m_go = 0;
  bit          m_block = 0;
  bit          prev_start = 0;
  int          n_double = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          accept_cyc = 0;

  ov7670_config_sequencer #(.DELAY_CYCLES(DLY), .ROM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_ready(sccb_ready), .sccb_start(sccb_start), .sccb_reg(sccb_reg),
    .sccb_val(sccb_val), .busy(busy), .done(done), .write_count(write_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Pulse monitor: records every write request seen mid-cycle
  always @(negedge clk) begin
    if (sccb_start === 1'b1) begin
      got_q.push_back({sccb_reg, sccb_val});
      pulse_q.push_back(cyc);
      if (prev_start) n_double++;
      m_go = 1;
    end
    prev_start = (sccb_start === 1'b1);
  end

  // SCCB master: drops ready just after the edge following a request, for m_lat cycles
  always @(posedge clk) begin
    #1;
    if (m_go) begin
      m_go = 0;
      m_cnt = m_lat;
      sccb_ready = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      sccb_ready = (m_cnt == 0) && !m_block;
    end else begin
      sccb_ready = !m_block;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic do_start();
    @(negedge clk);
    got_q.delete();
    pulse_q.delete();
    n_double = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && pulse_q.size() < n; i++) @(negedge clk);
  endtask

  // Reference: table semantics only (FFFF ends, FFF0 skipped, 256 entries max, count saturates)
  task automatic build_expect();
    int a;
    exp_q.delete();
    exp_addr = 255;
    for (a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) begin
        exp_addr = a;
        break;
      end
      if (rom[a] != 16'hFFF0) exp_q.push_back(rom[a]);
    end
    exp_wc = (exp_q.size() > 255) ? 255 : exp_q.size();
  endtask

  task automatic compare_run(input string tag);
    int n;
    build_expect();
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_wcount"}, write_count, exp_wc);
    check({tag, "_addr"}, rom_addr, exp_addr);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_double"}, n_double, 0);
  endtask

  function automatic logic [15:0] rand_write();
    logic [15:0] e;
    e = 16'($urandom);
    if (e[15:8] == 8'hFF || e[15:8] == 8'h12) e[15:8] = 8'h3A;
    return e;
  endfunction

  initial begin
    clear_rom();
    repeat (3) @(negedge clk);
    check("rst_addr", rom_addr, 8'd0);
    check("rst_start", sccb_start, 1'b0);
    check("rst_reg", sccb_reg, 8'd0);
    check("rst_val", sccb_val, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wc", write_count, 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic two-write table, ideal master
    rom[0] = 16'h1280; rom[1] = 16'h1180; rom[2] = 16'hFFFF;
    m_lat = 5;
    do_start();
    check("a_busy_after_start", busy, 1'b1);
    wait_done("a", 500);
    compare_run("a");
    check("a_done_level", done, 1'b1);
    check("a_first_latency", (pulse_q.size() >= 1) ? pulse_q[0] - accept_cyc : -1, 3);
    check("a_gap", (pulse_q.size() >= 2) ? pulse_q[1] - pulse_q[0] : -1, m_lat + 5 + POST_GAP);

    // Timed delay entry before a write
    clear_rom();
    rom[0] = 16'hFFF0; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
    m_lat = 3;
    do_start();
    wait_done("b", 500);
    compare_run("b");
    check("b_delay_latency", (pulse_q.size() >= 1) ? pulse_q[0] - accept_cyc : -1, 3 + DLY + 3);

    // Master not ready for 100 cycles while a write is pending
    clear_rom();
    rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
    m_lat = 2;
    @(negedge clk);
    m_block = 1;
    repeat (2) @(negedge clk);
    do_start();
    repeat (100) @(negedge clk);
    check("d_no_pulse_while_blocked", pulse_q.size(), 0);
    check("d_busy_while_blocked", busy, 1'b1);
    m_block = 0;
    wait_done("d", 200);
    compare_run("d");

    // Reset during WAIT_HI
    clear_rom();
    rom[0] = 16'h3A04; rom[1] = 16'h4B05; rom[2] = 16'hFFFF;
    m_lat = 20;
    do_start();
    wait_pulses(1, 100);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("e_rst_addr", rom_addr, 8'd0);
    check("e_rst_start", sccb_start, 1'b0);
    check("e_rst_reg", sccb_reg, 8'd0);
    check("e_rst_val", sccb_val, 8'd0);
    check("e_rst_busy", busy, 1'b0);
    check("e_rst_done", done, 1'b0);
    check("e_rst_wc", write_count, 8'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("e_no_more_pulses", pulse_q.size(), 1);
    check("e_addr_idle", rom_addr, 8'd0);
    check("e_busy_idle", busy, 1'b0);

    // start pulsed mid-pass must not restart the walk
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = rand_write();
    m_lat = 6;
    do_start();
    wait_pulses(1, 100);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("f", 500);
    compare_run("f");

    // Randomized short tables with interleaved delay entries
    for (int t = 0; t < 4; t++) begin
      int n;
      clear_rom();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 16'hFFF0 : rand_write();
      m_lat = $urandom_range(1, 6);
      do_start();
      wait_done($sformatf("r%0d", t), 1000);
      compare_run($sformatf("r%0d", t));
    end

    // Full 256-entry table without terminator
    for (int i = 0; i < 256; i++) rom[i] = rand_write();
    m_lat = 1;
    do_start();
    wait_done("c", 5000);
    compare_run("c");
    check("c_pulses", pulse_q.size(), 256);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
